// File: rtl/peripheral_bcdconv.sv
// Memory-mapped BCD <-> binary converter for the femtoRV bus.
// MODE selects direction; a single-bit-per-cycle double-dabble engine does the conversion.
module peripheral_bcdconv #(
    parameter int DIGITS = 5,
    parameter int BIN_W  = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    output logic        irq
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [31:0] LIMIT = 32'(10 ** DIGITS);

    localparam logic [4:0] ADDR_A      = 5'h04;
    localparam logic [4:0] ADDR_MODE   = 5'h08;
    localparam logic [4:0] ADDR_CTRL   = 5'h0C;
    localparam logic [4:0] ADDR_RESULT = 5'h10;
    localparam logic [4:0] ADDR_STATUS = 5'h14;

    typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

    state_t             state_reg;
    logic [31:0]        a_reg;
    logic               mode_reg;
    logic               irq_en_reg;
    logic [31:0]        result_reg;
    logic               done_reg;
    logic               busy_reg;
    logic               err_reg;
    logic               irq_reg;
    logic [31:0]        d_out_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic               wr_en;
    logic               rd_en;
    logic               start;
    logic [31:0]        rd_data;
    logic [31:0]        bin_ext;
    logic [31:0]        bcd_ext;
    logic [BCD_W-1:0]   bcd_shr;
    logic [BCD_W-1:0]   bcd_add3;
    logic [BCD_W-1:0]   bcd_sub3;
    logic [DIGITS-1:0]  nib_bad;

    assign wr_en   = cs && wr;
    assign rd_en   = cs && rd;
    assign start   = wr_en && (addr == ADDR_CTRL) && d_in[0];
    assign bin_ext = 32'(bin_reg);
    assign bcd_shr = bcd_reg >> 1;

    always_comb begin
        bcd_ext = '0;
        bcd_ext[BCD_W-1:0] = bcd_reg;
    end

    // Per-digit correction: +3 before a left shift, -3 after a right shift.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nib
            logic [3:0] nib_cur;
            logic [3:0] nib_shr;
            assign nib_cur = bcd_reg[4*gi +: 4];
            assign nib_shr = bcd_shr[4*gi +: 4];
            assign bcd_add3[4*gi +: 4] = (nib_cur >= 4'd5) ? nib_cur + 4'd3 : nib_cur;
            assign bcd_sub3[4*gi +: 4] = (nib_shr >= 4'd8) ? nib_shr - 4'd3 : nib_shr;
            assign nib_bad[gi] = (nib_cur > 4'd9);
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_A:      rd_data = a_reg;
            ADDR_MODE:   rd_data = {31'b0, mode_reg};
            ADDR_CTRL:   rd_data = {30'b0, irq_en_reg, 1'b0};
            ADDR_RESULT: rd_data = result_reg;
            ADDR_STATUS: rd_data = {29'b0, err_reg, busy_reg, done_reg};
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            mode_reg   <= 1'b0;
            irq_en_reg <= 1'b0;
            result_reg <= '0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            err_reg    <= 1'b0;
            irq_reg    <= 1'b0;
            d_out_reg  <= '0;
            bcd_reg    <= '0;
            bin_reg    <= '0;
            cnt_reg    <= '0;
        end else begin
            irq_reg <= 1'b0;
            if (rd_en) begin
                d_out_reg <= rd_data;
            end
            if (wr_en && (addr == ADDR_CTRL)) begin
                irq_en_reg <= d_in[1];
            end
            // Operand and direction are frozen for the whole conversion.
            if (wr_en && !busy_reg) begin
                if (addr == ADDR_A) begin
                    a_reg <= d_in;
                end
                if (addr == ADDR_MODE) begin
                    mode_reg <= d_in[0];
                end
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= CHECK;
                        done_reg  <= 1'b0;
                        err_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        if (mode_reg) begin
                            bin_reg <= a_reg[BIN_W-1:0];
                            bcd_reg <= '0;
                        end else begin
                            bin_reg <= '0;
                            bcd_reg <= a_reg[BCD_W-1:0];
                        end
                    end
                end
                CHECK: begin
                    if (mode_reg ? (bin_ext >= LIMIT) : (|nib_bad)) begin
                        err_reg   <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (mode_reg) begin
                        bcd_reg <= {bcd_add3[BCD_W-2:0], bin_reg[BIN_W-1]};
                        bin_reg <= bin_reg << 1;
                    end else begin
                        bin_reg <= {bcd_reg[0], bin_reg[BIN_W-1:1]};
                        bcd_reg <= bcd_sub3;
                    end
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (err_reg) begin
                        result_reg <= '0;
                    end else begin
                        result_reg <= mode_reg ? bcd_ext : bin_ext;
                    end
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    irq_reg   <= irq_en_reg;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign d_out = d_out_reg;
    assign irq   = irq_reg;
endmodule

// File: tb/tb_peripheral_bcdconv.sv
// Bench for peripheral_bcdconv: a 5-digit and a 2-digit instance checked against a
// transaction-level model every cycle, plus directed register reads with literal values.
module tb_peripheral_bcdconv;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs_s   [2];
    logic        rd_s   [2];
    logic        wr_s   [2];
    logic [4:0]  addr_s [2];
    logic [31:0] din_s  [2];
    logic [31:0] dout_s [2];
    logic        irq_s  [2];

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    peripheral_bcdconv dut5 (
        .clk(clk), .reset(reset), .d_in(din_s[0]), .cs(cs_s[0]), .addr(addr_s[0]),
        .rd(rd_s[0]), .wr(wr_s[0]), .d_out(dout_s[0]), .irq(irq_s[0])
    );

    peripheral_bcdconv #(.DIGITS(2), .BIN_W(7)) dut2 (
        .clk(clk), .reset(reset), .d_in(din_s[1]), .cs(cs_s[1]), .addr(addr_s[1]),
        .rd(rd_s[1]), .wr(wr_s[1]), .d_out(dout_s[1]), .irq(irq_s[1])
    );

    function automatic int digits_of(input int u);
        return (u == 0) ? 5 : 2;
    endfunction

    function automatic int binw_of(input int u);
        return (u == 0) ? 17 : 7;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (register-level behaviour) ----------------
    logic [31:0] m_a [2], m_result [2], m_pres [2], m_dout [2];
    logic        m_mode [2], m_irqen [2], m_done [2], m_busy [2], m_err [2], m_perr [2], m_irq [2];
    int          m_elapsed [2], m_total [2];

    // Plain arithmetic conversion of an operand; result is 0 when the operand is invalid.
    task automatic convert(input int u, input logic mode, input logic [31:0] a,
                           output logic e, output logic [31:0] r);
        longint v;
        longint x;
        longint d;
        e = 1'b0;
        r = '0;
        if (!mode) begin
            v = 0;
            for (int i = digits_of(u) - 1; i >= 0; i--) begin
                d = (a >> (4 * i)) & 15;
                if (d > 9) e = 1'b1;
                v = v * 10 + d;
            end
            if (!e) r = 32'(v);
        end else begin
            x = longint'(a) & ((longint'(1) << binw_of(u)) - 1);
            if (x >= 10 ** digits_of(u)) e = 1'b1;
            else begin
                for (int i = 0; i < digits_of(u); i++) begin
                    r = r | (32'(x % 10) << (4 * i));
                    x = x / 10;
                end
            end
        end
    endtask

    function automatic logic [31:0] m_read(input int u, input logic [4:0] a);
        case (a)
            5'h04:   return m_a[u];
            5'h08:   return {31'b0, m_mode[u]};
            5'h0C:   return {30'b0, m_irqen[u], 1'b0};
            5'h10:   return m_result[u];
            5'h14:   return {29'b0, m_err[u], m_busy[u], m_done[u]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step(input int u);
        logic old_busy;
        logic old_irqen;
        if (!reset) begin
            m_a[u] = '0; m_mode[u] = 1'b0; m_irqen[u] = 1'b0; m_result[u] = '0;
            m_done[u] = 1'b0; m_busy[u] = 1'b0; m_err[u] = 1'b0; m_irq[u] = 1'b0;
            m_dout[u] = '0; m_elapsed[u] = 0; m_total[u] = 0; m_perr[u] = 1'b0; m_pres[u] = '0;
            return;
        end
        m_irq[u] = 1'b0;
        if (cs_s[u] && rd_s[u]) m_dout[u] = m_read(u, addr_s[u]);
        old_busy = m_busy[u];
        old_irqen = m_irqen[u];
        if (old_busy) begin
            m_elapsed[u]++;
            // Validation takes one cycle, so an error flag shows up one cycle after start.
            if (m_elapsed[u] == 1) m_err[u] = m_perr[u];
            if (m_elapsed[u] == m_total[u]) begin
                m_result[u] = m_pres[u];
                m_done[u] = 1'b1;
                m_busy[u] = 1'b0;
                m_irq[u] = old_irqen;
            end
        end
        if (cs_s[u] && wr_s[u]) begin
            case (addr_s[u])
                5'h04: if (!old_busy) m_a[u] = din_s[u];
                5'h08: if (!old_busy) m_mode[u] = din_s[u][0];
                5'h0C: begin
                    m_irqen[u] = din_s[u][1];
                    if (din_s[u][0] && !old_busy) begin
                        convert(u, m_mode[u], m_a[u], m_perr[u], m_pres[u]);
                        m_busy[u] = 1'b1;
                        m_done[u] = 1'b0;
                        m_err[u] = 1'b0;
                        m_elapsed[u] = 0;
                        m_total[u] = m_perr[u] ? 2 : binw_of(u) + 2;
                    end
                end
                default: ;
            endcase
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("model_dout[%0d]", u), dout_s[u], m_dout[u]);
                chk($sformatf("model_irq[%0d]", u), 32'(irq_s[u]), 32'(m_irq[u]));
            end
        end
    end

    // ---------------- bus helpers (inputs change 2ns after the edge) ----------------
    task automatic bus(input int u, input logic w, input logic r, input logic [4:0] a, input logic [31:0] d);
        cs_s[u] = 1'b1; wr_s[u] = w; rd_s[u] = r; addr_s[u] = a; din_s[u] = d;
        @(posedge clk); #2;
        cs_s[u] = 1'b0; wr_s[u] = 1'b0; rd_s[u] = 1'b0;
    endtask

    task automatic bus_wr(input int u, input logic [4:0] a, input logic [31:0] d);
        bus(u, 1'b1, 1'b0, a, d);
    endtask

    task automatic bus_rd(input int u, input logic [4:0] a, output logic [31:0] v);
        bus(u, 1'b0, 1'b1, a, 32'h0);
        v = dout_s[u];
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic rd_chk(input int u, input logic [4:0] a, input logic [31:0] exp, input string name);
        logic [31:0] v;
        bus_rd(u, a, v);
        chk(name, v, exp);
    endtask

    // Start a conversion, poll STATUS every cycle until done, then read RESULT.
    task automatic run_conv(input int u, input logic mode, input logic [31:0] a, input logic ien,
                            input logic [31:0] exp_res, input logic [2:0] exp_stat, input string name);
        int lat;
        logic [31:0] v;
        lat = exp_stat[2] ? 2 : binw_of(u) + 2;
        bus_wr(u, 5'h08, {31'b0, mode});
        bus_wr(u, 5'h04, a);
        bus_wr(u, 5'h0C, {30'b0, ien, 1'b1});
        for (int j = 1; j <= lat + 1; j++) begin
            bus_rd(u, 5'h14, v);
            if (j <= lat) chk({name, "_busy"}, 32'(v[1]), 32'h1);
            else          chk({name, "_status"}, v, 32'(exp_stat));
            chk({name, "_irq"}, 32'(irq_s[u]), ((ien == 1'b1) && (j == lat)) ? 32'h1 : 32'h0);
        end
        rd_chk(u, 5'h10, exp_res, {name, "_result"});
        $display("conv %s: inst=%0d mode=%0d a=0x%0h -> result=0x%0h", name, u, mode, a, dout_s[u]);
    endtask

    initial begin
        logic [31:0] v;
        for (int u = 0; u < 2; u++) begin
            cs_s[u] = 1'b0; rd_s[u] = 1'b0; wr_s[u] = 1'b0; addr_s[u] = '0; din_s[u] = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        cmp_en = 1'b1;

        rd_chk(0, 5'h14, 32'h0, "reset_status");
        rd_chk(0, 5'h10, 32'h0, "reset_result");
        rd_chk(0, 5'h0C, 32'h0, "reset_ctrl");
        rd_chk(1, 5'h08, 32'h0, "reset_mode");

        run_conv(0, 1'b0, 32'h99999, 1'b0, 32'h1869F, 3'h1, "b2b_99999");
        run_conv(0, 1'b1, 32'd12345, 1'b1, 32'h12345, 3'h1, "bin_12345");
        rd_chk(0, 5'h0C, 32'h2, "ctrl_irq_en");
        run_conv(0, 1'b0, 32'h0001A, 1'b1, 32'h0, 3'h5, "bcd_bad_nib");
        run_conv(0, 1'b1, 32'd100000, 1'b1, 32'h0, 3'h5, "bin_overflow");
        run_conv(0, 1'b1, 32'd99999, 1'b0, 32'h99999, 3'h1, "bin_max");
        run_conv(0, 1'b0, 32'h0, 1'b0, 32'h0, 3'h1, "bcd_zero");
        rd_chk(0, 5'h00, 32'h0, "unmapped_00");
        rd_chk(0, 5'h18, 32'h0, "unmapped_18");

        // Writes during a conversion: A and a second start are dropped, irq_en still updates.
        bus_wr(0, 5'h0C, 32'h2);
        bus_wr(0, 5'h08, 32'h0);
        bus_wr(0, 5'h04, 32'h12345);
        bus_wr(0, 5'h0C, 32'h3);
        idle(4);
        bus_wr(0, 5'h04, 32'h00042);
        bus_wr(0, 5'h0C, 32'h1);
        idle(14);
        rd_chk(0, 5'h14, 32'h1, "busy_ign_status");
        rd_chk(0, 5'h10, 32'h3039, "busy_ign_result");
        rd_chk(0, 5'h04, 32'h12345, "busy_ign_a");
        rd_chk(0, 5'h0C, 32'h0, "busy_ctrl_upd");
        $display("conv busy_ignore: inst=0 result=0x3039 expected");

        // Reset in the middle of a conversion.
        bus_wr(0, 5'h04, 32'h99999);
        rd_chk(0, 5'h04, 32'h99999, "pre_reset_a");
        bus_wr(0, 5'h0C, 32'h1);
        idle(7);
        reset = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        chk("reset_dout", dout_s[0], 32'h0);
        rd_chk(0, 5'h14, 32'h0, "post_reset_status");
        rd_chk(0, 5'h10, 32'h0, "post_reset_result");
        rd_chk(0, 5'h04, 32'h0, "post_reset_a");
        $display("reset mid-conversion: inst=0 state cleared");
        run_conv(0, 1'b1, 32'd99999, 1'b0, 32'h99999, 3'h1, "after_reset");

        run_conv(1, 1'b0, 32'h99, 1'b0, 32'd99, 3'h1, "d2_b2b_99");
        run_conv(1, 1'b1, 32'h0, 1'b0, 32'h0, 3'h1, "d2_bin_0");
        run_conv(1, 1'b1, 32'd99, 1'b1, 32'h99, 3'h1, "d2_bin_99");
        run_conv(1, 1'b1, 32'd100, 1'b0, 32'h0, 3'h5, "d2_bin_100");
        run_conv(1, 1'b0, 32'h9A, 1'b0, 32'h0, 3'h5, "d2_bad_nib");
        run_conv(1, 1'b0, 32'h47, 1'b0, 32'd47, 3'h1, "d2_b2b_47");

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/peripheral_bcdconv.md
Name: peripheral_bcdconv

Overview:
- Memory-mapped BCD/binary converter peripheral for the femtoRV bus, generalising the single-direction 5-digit BCD-to-binary peripheral.
- Supports both directions through a MODE register: bcd2bin via reverse double-dabble, bin2bcd via double-dabble.
- Digit count is parametrised. Adds input validation, an overflow check, busy/error status and an optional completion interrupt.
- Converter datapath is internal; no separate core instance.

Parameters:
- DIGITS, 5, number of BCD digits handled; 1..8.
- BIN_W, 17, binary width; must be >= ceil(log2(10^DIGITS)) and <= 27 (for example 17 for 5 digits, 7 for 2 digits).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset. Sampled on the rising edge of clk; 0 = reset.
- d_in  in  32  bus write data.
- cs  in  1  peripheral select.
- addr  in  5  register address (byte offset).
- rd  in  1  bus read strobe.
- wr  in  1  bus write strobe.
- d_out  out  32  registered read data.
- irq  out  1  one-cycle completion pulse.

Behaviour:
- Register map (write takes effect when cs&&wr at the rising edge):
  - 0x04 A: operand, R/W. Write stores d_in; read returns A.
  - 0x08 MODE: bit0 selects direction, R/W. 0 = bcd2bin, 1 = bin2bcd.
  - 0x0C CTRL: bit0 = start (write-1 pulse, not stored); bit1 = irq_en (stored; reads return {30'b0, irq_en, 1'b0}).
  - 0x10 RESULT: read-only. bcd2bin: {zero, BIN_W result}. bin2bcd: {zero, 4*DIGITS packed BCD}.
  - 0x14 STATUS: read-only. {29'b0, err, busy, done}.
  - Other addresses read 0; writes ignored.
- Reset (reset==0 at an edge): A=0, MODE=0, irq_en=0, RESULT=0, done=0, busy=0, err=0, irq=0, d_out=0, state=IDLE. Reset has priority over any bus access and aborts a conversion mid-operation.
- Read path:
  - If cs&&rd at edge k, d_out holds the selected register from edge k.
  - Otherwise d_out holds its previous value.
- FSM states IDLE, CHECK, SHIFT, DONE:
  - IDLE: a start write moves to CHECK. It clears done and err, sets busy, loads the working registers from A (bcd2bin uses A[4*DIGITS-1:0]; bin2bcd uses A[BIN_W-1:0]), and zeros the shift counter.
  - CHECK (1 cycle):
    - bcd2bin: if any nibble > 9, go to DONE with err=1.
    - bin2bcd: if operand >= 10^DIGITS, go to DONE with err=1.
    - Otherwise go to SHIFT.
  - SHIFT (exactly BIN_W cycles, one bit per cycle):
    - bin2bcd: add 3 to each BCD nibble >= 5, then shift left, pulling in the binary MSB.
    - bcd2bin: shift right into the binary register, then subtract 3 from each nibble >= 8.
    - On the last cycle, go to DONE.
  - DONE: load RESULT (forced to 0 when err=1), set done=1, clear busy, pulse irq=1 for one cycle if irq_en, then return to IDLE.
- Latency with start written at edge k:
  - Success: done=1 visible after edge k+BIN_W+2.
  - Error: done=1 visible after edge k+2.
  - Example, DIGITS=5: 19 cycles.
- done and err are sticky until the next accepted start.
- While busy: start writes and writes to A or MODE are ignored, and RESULT keeps its old value. A CTRL write still updates irq_en.
- A start written in the same cycle the FSM returns to IDLE is accepted.
- The A register contents are not modified by a conversion.

Test Plan:
- DIGITS=5, MODE=0, A=0x99999, start -> at cycle 19 STATUS=0x1, RESULT=0x1869F (99999), busy=1 during cycles 1..18.
- MODE=1, A=0x3039 (12345), irq_en=1, start -> RESULT=0x12345, STATUS=0x1, irq high exactly one cycle, coincident with done rising.
- MODE=0, A=0x0001A -> after 2 cycles STATUS=0x5 (err|done), RESULT=0. MODE=1, A=100000 -> STATUS=0x5, RESULT=0.
- Start, then at cycle 5 write A=0x00042 and a second start -> both ignored, the first conversion completes with the correct RESULT, A still reads the original value.
- reset=0 at cycle 8 of a conversion -> next cycle STATUS=0, RESULT=0, d_out=0. A new start after reset converts correctly.
- Instance DIGITS=2, BIN_W=7: MODE=0, A=0x99 -> RESULT=99 after 9 cycles. MODE=1, A=0 -> RESULT=0x00, err=0.
